// File: rtl/ibuf_feeder_if.sv
// CPU RAM-bus and array-lane signals of one input-buffer lane feeder.
// master: the CPU/controller side; slave: the feeder itself.
interface ibuf_feeder_if;
    logic [7:0]  sbus_wadr;
    logic [15:0] sbus_wdata;
    logic        sbus_wen;
    logic [7:0]  sbus_radr;
    logic [15:0] sbus_rdata;
    logic        start;
    logic [7:0]  start_adr;
    logic [7:0]  run_cntr;
    logic        adv;
    logic [15:0] a_out;
    logic        a_valid;
    logic        a_running;
    logic        a_finish;

    modport master (
        output sbus_wadr, sbus_wdata, sbus_wen, sbus_radr,
        output start, start_adr, run_cntr, adv,
        input  sbus_rdata, a_out, a_valid, a_running, a_finish
    );

    modport slave (
        input  sbus_wadr, sbus_wdata, sbus_wen, sbus_radr,
        input  start, start_adr, run_cntr, adv,
        output sbus_rdata, a_out, a_valid, a_running, a_finish
    );
endinterface

// File: rtl/ibuf_feeder.sv
// Input lane feeder: a 256x16 CPU-filled buffer streamed into one systolic
// array lane, preceded by LANE_DELAY zero beats (diagonal skew) and followed
// by TAIL_LEN zero beats (array flush).
//
// a_out/a_valid present the current beat's item; the array consumes it on a
// clock edge with adv=1, and on that same edge the next item is loaded. The
// buffer read for a data item happens on the edge it becomes visible, so a
// CPU write landing on that edge (or later) does not change the streamed value,
// while writes to entries not yet loaded are picked up.
module ibuf_feeder #(
    parameter int LANE_DELAY = 0,
    parameter int TAIL_LEN   = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    ibuf_feeder_if.slave  bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SKEW   = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_TAIL   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [3:0] SKEW_INIT = 4'(LANE_DELAY);
    localparam logic [3:0] TAIL_INIT = 4'(TAIL_LEN);

    logic [15:0] mem [256];
    logic [2:0]  state;
    logic [7:0]  rd_ptr;
    logic [7:0]  data_cnt;
    logic [3:0]  skew_cnt;
    logic [3:0]  tail_cnt;
    logic [15:0] a_out_r;
    logic        a_valid_r;
    logic [15:0] rdata_r;
    logic [15:0] fetch;

    assign fetch = mem[rd_ptr];

    // CPU write port; buffer contents survive reset
    always_ff @(posedge clk) begin
        if (bus.sbus_wen) begin
            mem[bus.sbus_wadr] <= bus.sbus_wdata;
        end
    end

    // CPU readback port, read-before-write on a same-address collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 16'd0;
        end else begin
            rdata_r <= mem[bus.sbus_radr];
        end
    end

    // Run sequencer: start/restart, skew, stream with one read per beat, tail
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rd_ptr    <= 8'd0;
            data_cnt  <= 8'd0;
            skew_cnt  <= 4'd0;
            tail_cnt  <= 4'd0;
            a_out_r   <= 16'd0;
            a_valid_r <= 1'b0;
        end else if (bus.start) begin
            // start wins over a beat and abandons any run in progress
            rd_ptr    <= bus.start_adr;
            data_cnt  <= bus.run_cntr;
            skew_cnt  <= 4'd0;
            tail_cnt  <= 4'd0;
            a_out_r   <= 16'd0;
            a_valid_r <= 1'b0;
            state     <= (bus.run_cntr == 8'd0) ? S_DONE : S_LOAD;
        end else begin
            case (state)
                S_IDLE: begin
                    a_out_r   <= 16'd0;
                    a_valid_r <= 1'b0;
                end
                S_LOAD: begin
                    skew_cnt <= SKEW_INIT;
                    if (LANE_DELAY > 0) begin
                        state     <= S_SKEW;
                        a_out_r   <= 16'd0;
                        a_valid_r <= 1'b0;
                    end else begin
                        state     <= S_STREAM;
                        a_out_r   <= fetch;
                        a_valid_r <= 1'b1;
                        rd_ptr    <= rd_ptr + 8'd1;
                    end
                end
                S_SKEW: begin
                    if (bus.adv) begin
                        skew_cnt <= skew_cnt - 4'd1;
                        if (skew_cnt == 4'd1) begin
                            state     <= S_STREAM;
                            a_out_r   <= fetch;
                            a_valid_r <= 1'b1;
                            rd_ptr    <= rd_ptr + 8'd1;
                        end
                    end
                end
                S_STREAM: begin
                    if (bus.adv) begin
                        data_cnt <= data_cnt - 8'd1;
                        if (data_cnt == 8'd1) begin
                            a_out_r   <= 16'd0;
                            a_valid_r <= 1'b0;
                            tail_cnt  <= TAIL_INIT;
                            state     <= (TAIL_LEN > 0) ? S_TAIL : S_DONE;
                        end else begin
                            a_out_r   <= fetch;
                            a_valid_r <= 1'b1;
                            rd_ptr    <= rd_ptr + 8'd1;
                        end
                    end
                end
                S_TAIL: begin
                    if (bus.adv) begin
                        tail_cnt <= tail_cnt - 4'd1;
                        if (tail_cnt == 4'd1) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    a_out_r   <= 16'd0;
                    a_valid_r <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    a_out_r   <= 16'd0;
                    a_valid_r <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sbus_rdata = rdata_r;
    assign bus.a_out      = a_out_r;
    assign bus.a_valid    = a_valid_r;
    assign bus.a_running  = (state == S_LOAD) || (state == S_SKEW) ||
                            (state == S_STREAM) || (state == S_TAIL);
    assign bus.a_finish   = (state == S_DONE);

endmodule

// File: tb/tb_ibuf_feeder.sv
// Bench for ibuf_feeder: two lanes (no skew/tail and skew 2/tail 3) share the
// same stimulus; a beat-index reference model predicts every output each cycle.
module tb_ibuf_feeder;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  wadr = 8'd0, radr = 8'd0, sadr = 8'd0, scnt = 8'd0;
    logic [15:0] wdata = 16'd0;
    logic        wen = 1'b0, start = 1'b0, adv = 1'b0;

    ibuf_feeder_if if0 ();
    ibuf_feeder_if if1 ();

    assign if0.sbus_wadr = wadr;   assign if1.sbus_wadr = wadr;
    assign if0.sbus_wdata = wdata; assign if1.sbus_wdata = wdata;
    assign if0.sbus_wen = wen;     assign if1.sbus_wen = wen;
    assign if0.sbus_radr = radr;   assign if1.sbus_radr = radr;
    assign if0.start = start;      assign if1.start = start;
    assign if0.start_adr = sadr;   assign if1.start_adr = sadr;
    assign if0.run_cntr = scnt;    assign if1.run_cntr = scnt;
    assign if0.adv = adv;          assign if1.adv = adv;

    ibuf_feeder #(.LANE_DELAY(0), .TAIL_LEN(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    ibuf_feeder #(.LANE_DELAY(2), .TAIL_LEN(3)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    // reference model: each run is a sequence of LD zero beats, N buffer
    // entries, TL zero beats; m_pos is the index of the beat on display
    logic [15:0] shadow [256];
    int          m_ld [2] = '{0, 2};
    int          m_tl [2] = '{0, 3};
    bit          m_load [2], m_act [2], m_fin [2];
    int          m_pos [2], m_n [2];
    logic [7:0]  m_base [2];
    logic [15:0] m_rd;
    bit          rd_chk = 1'b0;
    int          run_cnt [2];
    int          n_chk = 0, n_err = 0;
    logic [7:0]  cur_base;
    int          cur_n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_load[i] = 1'b0; m_act[i] = 1'b0; m_fin[i] = 1'b0;
            m_pos[i] = 0; m_n[i] = 0; m_base[i] = 8'd0;
        end
        m_rd = 16'd0;
    endtask

    task automatic model_edge(input int i);
        m_fin[i] = 1'b0;
        if (start) begin
            m_base[i] = sadr;
            m_n[i]    = int'(scnt);
            m_pos[i]  = 0;
            m_load[i] = (scnt != 8'd0);
            m_act[i]  = (scnt != 8'd0);
            m_fin[i]  = (scnt == 8'd0);
        end else if (m_load[i]) begin
            m_load[i] = 1'b0;
        end else if (m_act[i] && adv) begin
            m_pos[i]++;
            if (m_pos[i] == m_ld[i] + m_n[i] + m_tl[i]) begin
                m_act[i] = 1'b0;
                m_fin[i] = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [15:0] ed, od, ord;
        logic        ev, ov, orun, ofin;
        int          p;
        for (int i = 0; i < 2; i++) begin
            ev = 1'b0; ed = 16'd0;
            p = m_pos[i] - m_ld[i];
            if (m_act[i] && !m_load[i] && p >= 0 && p < m_n[i]) begin
                ev = 1'b1;
                ed = shadow[8'(int'(m_base[i]) + p)];
            end
            od   = (i == 0) ? if0.a_out      : if1.a_out;
            ov   = (i == 0) ? if0.a_valid    : if1.a_valid;
            orun = (i == 0) ? if0.a_running  : if1.a_running;
            ofin = (i == 0) ? if0.a_finish   : if1.a_finish;
            ord  = (i == 0) ? if0.sbus_rdata : if1.sbus_rdata;
            if (orun) run_cnt[i]++;
            check($sformatf("u%0d.a_out", i), 32'(od), 32'(ed));
            check($sformatf("u%0d.a_valid", i), 32'(ov), 32'(ev));
            check($sformatf("u%0d.a_running", i), 32'(orun), 32'(m_act[i]));
            check($sformatf("u%0d.a_finish", i), 32'(ofin), 32'(m_fin[i]));
            if (rd_chk) check($sformatf("u%0d.sbus_rdata", i), 32'(ord), 32'(m_rd));
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            model_edge(0);
            model_edge(1);
            m_rd = shadow[radr];
        end
        if (wen) shadow[wadr] = wdata;
        @(negedge clk);
        check_outputs();
    endtask

    function automatic bit busy();
        return m_act[0] || m_act[1] || m_fin[0] || m_fin[1];
    endfunction

    task automatic write_word(input logic [7:0] a, input logic [15:0] d);
        wen = 1'b1; wadr = a; wdata = d;
        step();
        wen = 1'b0;
    endtask

    task automatic start_run(input logic [7:0] a, input logic [7:0] n);
        sadr = a; scnt = n; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_to_idle(input string tag);
        for (int k = 0; k < 200 && busy(); k++) step();
        check({tag, "_idle"}, 32'(busy()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_u0", {if0.a_out, if0.a_valid, if0.a_running, if0.a_finish, if0.sbus_rdata}, 32'd0);
        check("rst_u1", {if1.a_out, if1.a_valid, if1.a_running, if1.a_finish, if1.sbus_rdata}, 32'd0);
        @(negedge clk);
        step(); step();
        rst_n = 1'b1;

        // fill the whole buffer, then arm readback checking
        for (int a = 0; a < 256; a++) write_word(8'(a), 16'($urandom));
        radr = 8'd0;
        step();
        rd_chk = 1'b1;
        write_word(8'h00, 16'h0011); write_word(8'h01, 16'h0022);
        write_word(8'h02, 16'h0033); write_word(8'h03, 16'h0044);

        // basic run with adv held high, running-cycle totals
        adv = 1'b1;
        run_cnt[0] = 0; run_cnt[1] = 0;
        start_run(8'h00, 8'd4);
        run_to_idle("basic");
        check("run_len_u0", 32'(run_cnt[0]), 32'd5);
        check("run_len_u1", 32'(run_cnt[1]), 32'd10);

        // adv toggling once streaming
        start_run(8'h00, 8'd4);
        step();
        for (int k = 0; k < 7; k++) begin
            adv = (7'b1011001 >> (6 - k)) & 7'd1;
            step();
        end
        adv = 1'b1;
        run_to_idle("adv_toggle");

        // address wrap 0xFF -> 0x00
        write_word(8'hFE, 16'h000A); write_word(8'hFF, 16'h000B); write_word(8'h00, 16'h000C);
        start_run(8'hFE, 8'd3);
        run_to_idle("wrap");

        // empty run, then restart in mid-stream
        start_run(8'h40, 8'd0);
        run_to_idle("zero");
        start_run(8'h00, 8'd4);
        step(); step();
        start_run(8'h80, 8'd5);
        run_to_idle("restart");

        // write to an entry ahead of the stream is picked up
        adv = 1'b0;
        start_run(8'h10, 8'd4);
        write_word(8'h13, 16'hBEEF);
        adv = 1'b1;
        run_to_idle("write_ahead");

        // readback
        write_word(8'h05, 16'h1234);
        radr = 8'h05;
        step();
        check("rdback", 32'(if0.sbus_rdata), 32'h1234);

        // asynchronous reset in mid-stream
        start_run(8'h00, 8'd4);
        step(); step();
        rst_n = 1'b0;
        #1;
        check("rstmid_u0", {if0.a_out, if0.a_valid, if0.a_running, if0.a_finish, if0.sbus_rdata}, 32'd0);
        check("rstmid_u1", {if1.a_out, if1.a_valid, if1.a_running, if1.a_finish, if1.sbus_rdata}, 32'd0);
        model_reset();
        step(); step();
        rst_n = 1'b1;
        step();

        // randomized runs with random beats, CPU traffic and restarts
        for (int r = 0; r < 40; r++) begin
            cur_base = 8'($urandom);
            cur_n = $urandom_range(0, 8);
            sadr = cur_base; scnt = 8'(cur_n); start = 1'b1;
            adv = 1'($urandom % 2);
            wen = (($urandom % 3) == 0);
            wadr = cur_base + 8'd16 + 8'($urandom % 224);
            wdata = 16'($urandom); radr = 8'($urandom);
            step();
            start = 1'b0;
            for (int k = 0; k < 200 && busy(); k++) begin
                adv = (($urandom % 4) != 0);
                if (($urandom % 30) == 0) begin
                    cur_base = 8'($urandom);
                    cur_n = $urandom_range(0, 8);
                    sadr = cur_base; scnt = 8'(cur_n); start = 1'b1;
                end
                wen = (($urandom % 3) == 0);
                wadr = cur_base + 8'd16 + 8'($urandom % 224);
                wdata = 16'($urandom); radr = 8'($urandom);
                step();
                start = 1'b0;
            end
            wen = 1'b0;
            check("rand_idle", 32'(busy()), 32'd0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
